// File: rtl/bs_sched_pkg.sv
// ============================================================================
// Module      : bs_sched_pkg
// Description : Shared sizes, lane state encoding and pointer helper for the
//               Black-Scholes lane dispatch scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bs_sched_pkg;

  localparam int BSMODS   = 20;
  localparam int DATASIZE = 192;
  localparam int RESW     = 64;
  localparam int IDXW     = $clog2(BSMODS);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LOADED  = 2'd1,
    RUNNING = 2'd2,
    HOLD    = 2'd3
  } lane_state_e;

  // Round-robin pointer advance with wrap from the last lane back to lane 0.
  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] idx);
    return (idx == IDXW'(BSMODS - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bs_rr_arbiter.sv
// ============================================================================
// Module      : bs_rr_arbiter
// Description : Combinational round-robin arbiter; the search starts at ptr_i
//               and wraps, returning a one-hot grant and its index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bs_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int idx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = IW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bs_dispatch_scheduler.sv
// ============================================================================
// Module      : bs_dispatch_scheduler
// Description : Loads option packets into free Black-Scholes lanes, starts the
//               cores and merges lane results into one valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bs_dispatch_scheduler
  import bs_sched_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pkt_valid,
  input  logic [DATASIZE-1:0]         pkt_data,
  output logic                        pkt_ready,
  output logic [DATASIZE-1:0]         FullPacket,
  output logic [BSMODS-1:0]           regEn,
  input  logic [BSMODS-1:0]           REG_READY,
  input  logic [BSMODS-1:0]           hasUnusedData,
  output logic [BSMODS-1:0]           BS_START,
  input  logic [BSMODS-1:0]           BS_IDLE,
  input  logic [BSMODS-1:0]           BS_DONE,
  input  logic [BSMODS-1:0][RESW-1:0] ap_return,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [RESW-1:0]             res_data,
  output logic [IDXW-1:0]             res_lane,
  output logic [IDXW:0]               lanes_busy,
  output logic                        err_spurious
);

  logic [BSMODS-1:0]           eligible, hold_req, busy_d, start_d, spur_d;
  logic [BSMODS-1:0][RESW-1:0] result_vec;
  logic [BSMODS-1:0]           d_gnt, o_gnt;
  logic [IDXW-1:0]             d_idx, o_idx;
  logic                        d_any, o_any;
  logic                        disp_fire, out_fire, slot_free;
  logic [IDXW:0]               busy_cnt_d;

  logic [DATASIZE-1:0]         full_packet_q;
  logic [BSMODS-1:0]           reg_en_q, bs_start_q;
  logic [IDXW-1:0]             disp_ptr_q, res_ptr_q, res_lane_q;
  logic                        res_valid_q, err_q;
  logic [RESW-1:0]             res_data_q;
  logic [IDXW:0]               lanes_busy_q;

  assign pkt_ready = |eligible;
  assign disp_fire = pkt_valid && d_any;
  assign slot_free = !res_valid_q || res_ready;
  assign out_fire  = slot_free && o_any;

  bs_rr_arbiter #(.N(BSMODS), .IW(IDXW)) u_disp_arb (
    .req_i (eligible),
    .ptr_i (disp_ptr_q),
    .gnt_o (d_gnt),
    .idx_o (d_idx),
    .any_o (d_any)
  );

  bs_rr_arbiter #(.N(BSMODS), .IW(IDXW)) u_out_arb (
    .req_i (hold_req),
    .ptr_i (res_ptr_q),
    .gnt_o (o_gnt),
    .idx_o (o_idx),
    .any_o (o_any)
  );

  for (genvar u = 0; u < BSMODS; u++) begin : g_lane
    lane_state_e     state_q, state_d;
    logic [RESW-1:0] result_q;
    logic            start_l, spur_l;

    always_comb begin
      state_d = state_q;
      start_l = 1'b0;
      spur_l  = BS_DONE[u] && (state_q != RUNNING);
      case (state_q)
        FREE:    if (disp_fire && d_gnt[u]) state_d = LOADED;
        LOADED:  if (hasUnusedData[u] && BS_IDLE[u]) begin
                   state_d = RUNNING;
                   start_l = 1'b1;
                 end
        RUNNING: if (BS_DONE[u]) state_d = HOLD;
        HOLD:    if (out_fire && o_gnt[u]) state_d = FREE;
        default: state_d = FREE;
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) state_q <= FREE;
      else       state_q <= state_d;
    end

    // Result only matters while HOLD, so it needs no reset value.
    always_ff @(posedge clock) begin
      if (state_q == RUNNING && BS_DONE[u]) result_q <= ap_return[u];
    end

    assign eligible[u]   = (state_q == FREE) && REG_READY[u] && !hasUnusedData[u];
    assign hold_req[u]   = (state_q == HOLD);
    assign busy_d[u]     = (state_d != FREE);
    assign start_d[u]    = start_l;
    assign spur_d[u]     = spur_l;
    assign result_vec[u] = result_q;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < BSMODS; i++) busy_cnt_d = busy_cnt_d + (IDXW+1)'(busy_d[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_packet_q <= '0;
      reg_en_q      <= '0;
      bs_start_q    <= '0;
      disp_ptr_q    <= '0;
      res_ptr_q     <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_lane_q    <= '0;
      lanes_busy_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      reg_en_q     <= disp_fire ? d_gnt : '0;
      bs_start_q   <= start_d;
      lanes_busy_q <= busy_cnt_d;
      err_q        <= err_q | (|spur_d);
      if (disp_fire) begin
        full_packet_q <= pkt_data;
        disp_ptr_q    <= wrap_inc(d_idx);
      end
      // The slot reloads on the same edge it is consumed, sustaining 1 result/cycle.
      if (out_fire) begin
        res_valid_q <= 1'b1;
        res_data_q  <= result_vec[o_idx];
        res_lane_q  <= o_idx;
        res_ptr_q   <= wrap_inc(o_idx);
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign FullPacket   = full_packet_q;
  assign regEn        = reg_en_q;
  assign BS_START     = bs_start_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_lane     = res_lane_q;
  assign lanes_busy   = lanes_busy_q;
  assign err_spurious = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bs_dispatch_scheduler.sv
// ============================================================================
// Module      : tb_bs_dispatch_scheduler
// Description : Directed self-checking bench for bs_dispatch_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bs_dispatch_scheduler;
  import bs_sched_pkg::*;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        pkt_valid;
  logic [DATASIZE-1:0]         pkt_data;
  logic                        pkt_ready;
  logic [DATASIZE-1:0]         FullPacket;
  logic [BSMODS-1:0]           regEn, REG_READY, hasUnusedData, BS_START, BS_IDLE, BS_DONE;
  logic [BSMODS-1:0][RESW-1:0] ap_return;
  logic                        res_valid, res_ready;
  logic [RESW-1:0]             res_data;
  logic [IDXW-1:0]             res_lane;
  logic [IDXW:0]               lanes_busy;
  logic                        err_spurious;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [BSMODS-1:0] M3 = 20'h01088;  // lanes 3,7,12
  localparam logic [BSMODS-1:0] M4 = 20'h00216;  // lanes 1,2,4,9
  localparam logic [DATASIZE-1:0] D1 = {64'hDEADBEEF_00000001, 64'h12345678_9ABCDEF0, 64'h0F0F0F0F_F0F0F0F0};

  always #5 clock = ~clock;

  bs_dispatch_scheduler dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready), .FullPacket(FullPacket), .regEn(regEn), .REG_READY(REG_READY),
    .hasUnusedData(hasUnusedData), .BS_START(BS_START), .BS_IDLE(BS_IDLE), .BS_DONE(BS_DONE),
    .ap_return(ap_return), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_lane(res_lane), .lanes_busy(lanes_busy), .err_spurious(err_spurious)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATASIZE-1:0] obs, input logic [DATASIZE-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; pkt_data = '0; REG_READY = '1; hasUnusedData = '0;
    BS_IDLE = '1; BS_DONE = '0; ap_return = '0; res_ready = 1'b0;
    repeat (3) tick();
    check("rst_regEn", regEn, 0);
    check("rst_start", BS_START, 0);
    check("rst_valid", res_valid, 0);
    check("rst_err", err_spurious, 0);
    check("rst_busy", lanes_busy, 0);
    check("rst_pkt", FullPacket, 0);
    check("rst_ready", pkt_ready, 1);
    reset = 1'b0;
    tick();

    // Single packet through lane 0
    REG_READY = 20'h00001; pkt_valid = 1'b1; pkt_data = D1;
    #1 check("t1_ready", pkt_ready, 1);
    tick();
    pkt_valid = 1'b0;
    check("t1_regEn", regEn, 20'h00001);
    check("t1_pkt", FullPacket, D1);
    check("t1_busy", lanes_busy, 1);
    check("t1_nostart", BS_START, 0);
    #1 check("t1_ready_lo", pkt_ready, 0);
    hasUnusedData = 20'h00001;
    tick();
    check("t1_start", BS_START, 20'h00001);
    check("t1_regEn_off", regEn, 0);
    hasUnusedData = '0; BS_IDLE = 20'hFFFFE;
    tick();
    check("t1_start_off", BS_START, 0);
    BS_DONE = 20'h00001; ap_return[0] = 64'h1234;
    tick();
    BS_DONE = '0; res_ready = 1'b1;
    check("t1_valid_n1", res_valid, 0);
    tick();
    check("t1_valid", res_valid, 1);
    check("t1_data", res_data, 64'h1234);
    check("t1_lane", res_lane, 0);
    tick();
    check("t1_drain", res_valid, 0);
    check("t1_busy0", lanes_busy, 0);
    BS_IDLE = '1; REG_READY = '1;

    // Fresh pointers, then fill all lanes with 25 back-to-back packets
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      pkt_valid = 1'b1; pkt_data = DATASIZE'(100 + i);
      #1 check("t2_ready", pkt_ready, (i < 20) ? 1 : 0);
      tick();
      if (i < 20) begin
        check("t2_regEn", regEn, 1 << i);
        check("t2_pkt", FullPacket, 100 + i);
      end else begin
        check("t2_regEn_full", regEn, 0);
      end
    end
    pkt_valid = 1'b0;
    check("t2_busy", lanes_busy, 20);
    check("t2_ready_full", pkt_ready, 0);

    // Start 6 lanes, then reset mid-operation
    hasUnusedData = 20'h0003F;
    tick();
    check("t6_start", BS_START, 20'h0003F);
    hasUnusedData = '0;
    reset = 1'b1; REG_READY = 20'h00005;
    tick();
    check("t6_regEn", regEn, 0);
    check("t6_start0", BS_START, 0);
    check("t6_valid", res_valid, 0);
    check("t6_busy", lanes_busy, 0);
    check("t6_pkt", FullPacket, 0);
    check("t6_err", err_spurious, 0);
    check("t6_ready", pkt_ready, 1);
    REG_READY = '0;
    #1 check("t6_ready_lo", pkt_ready, 0);
    reset = 1'b0; REG_READY = '1;
    tick();

    // Lanes 3,7,12 complete in the same cycle
    REG_READY = M3; pkt_valid = 1'b1;
    tick(); check("t3_disp3", regEn, 1 << 3);
    tick(); check("t3_disp7", regEn, 1 << 7);
    tick(); check("t3_disp12", regEn, 1 << 12);
    pkt_valid = 1'b0; hasUnusedData = M3;
    tick();
    check("t3_start", BS_START, M3);
    hasUnusedData = '0; BS_DONE = M3;
    ap_return[3] = 64'hA3; ap_return[7] = 64'hA7; ap_return[12] = 64'hAC;
    tick();
    BS_DONE = '0; res_ready = 1'b1;
    check("t3_valid_n1", res_valid, 0);
    tick(); check("t3_lane_a", res_lane, 3);  check("t3_data_a", res_data, 64'hA3);
    tick(); check("t3_lane_b", res_lane, 7);  check("t3_data_b", res_data, 64'hA7);
    tick(); check("t3_lane_c", res_lane, 12); check("t3_data_c", res_data, 64'hAC);
    check("t3_valid_c", res_valid, 1);
    tick(); check("t3_drain", res_valid, 0);

    // Backpressure with 4 HOLD lanes; dispatch pointer wraps from 13 to lane 1
    res_ready = 1'b0; REG_READY = M4; pkt_valid = 1'b1;
    tick(); check("t4_disp1", regEn, 1 << 1);
    tick(); check("t4_disp2", regEn, 1 << 2);
    tick(); check("t4_disp4", regEn, 1 << 4);
    tick(); check("t4_disp9", regEn, 1 << 9);
    pkt_valid = 1'b0; hasUnusedData = M4;
    tick();
    check("t4_start", BS_START, M4);
    hasUnusedData = '0; BS_DONE = M4;
    ap_return[1] = 64'hB1; ap_return[2] = 64'hB2; ap_return[4] = 64'hB4; ap_return[9] = 64'hB9;
    tick();
    BS_DONE = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_lane", res_lane, 1);
      check("t4_hold_data", res_data, 64'hB1);
      check("t4_hold_busy", lanes_busy, 3);
      tick();
    end
    res_ready = 1'b1;
    tick(); check("t4_lane_b", res_lane, 2); check("t4_data_b", res_data, 64'hB2);
    tick(); check("t4_lane_c", res_lane, 4); check("t4_data_c", res_data, 64'hB4);
    tick(); check("t4_lane_d", res_lane, 9); check("t4_data_d", res_data, 64'hB9);
    tick(); check("t4_drain", res_valid, 0); check("t4_busy0", lanes_busy, 0);

    // Spurious completion on a FREE lane
    check("t5_err_pre", err_spurious, 0);
    BS_DONE = 20'h00020;
    tick();
    BS_DONE = '0;
    check("t5_err", err_spurious, 1);
    check("t5_novalid", res_valid, 0);
    repeat (3) tick();
    check("t5_err_sticky", err_spurious, 1);
    check("t5_novalid2", res_valid, 0);
    check("t5_busy", lanes_busy, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_err_clr", err_spurious, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
